// File: rtl/cpu_run_monitor.sv
// Run-control and trace monitor for the single-cycle RISC-V core.
// Latency: every output is registered; an event sampled at edge N is visible right after edge N.
// Flow control: none. The monitor never stalls the core. In DONE/TIMEOUT it raises halt so that the core's clock enable can be gated.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset (highest priority)
//   start, clear             run control pulses (IDLE->RUN, any state->IDLE with counters zeroed)
//   pc, pc_next              fetch stream, used to detect the loop back-edge
//   reg_we/reg_waddr/wdata   register-file write port, folded into reg_sig
//   mem_we/mem_addr/wdata    data-memory write port, folded into mem_sig
//   halt, status             run state (0=IDLE 1=RUN 2=DONE 3=TIMEOUT); halt = status[1]
//   loop_count, cycle_count  saturating back-edge and RUN-cycle counters
//   reg_sig, mem_sig         rotate-xor write signatures
//
// Build option: define RUN_MON_MEM_SIG_EN to enable the memory-write signature.
// When it is not defined, mem_sig reads 0 and the memory write port is ignored.
module cpu_run_monitor #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] LOOP_PC        = XLEN'(32'h0000100C),
    parameter logic [XLEN-1:0] LOOP_TARGET    = XLEN'(32'h00001000),
    parameter int              LOOP_LIMIT     = 10,
    parameter int              CNT_W          = 8,
    parameter int              TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  pc_next,
    input  logic             reg_we,
    input  logic [4:0]       reg_waddr,
    input  logic [XLEN-1:0]  reg_wdata,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             halt,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] loop_count,
    output logic [31:0]      cycle_count,
    output logic [XLEN-1:0]  reg_sig,
    output logic [XLEN-1:0]  mem_sig
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] LIMIT_U   = 32'(LOOP_LIMIT);
    localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT_CYCLES);

    state_t           state_q;
    logic [CNT_W-1:0] loop_count_q;
    logic [31:0]      cycle_count_q;
    logic [XLEN-1:0]  reg_sig_q;

    // Candidate values for the current RUN cycle. The state decision uses
    // these (not the _q values) so that the cycle's own update counts.
    logic             back_edge;
    logic [CNT_W-1:0] loop_count_d;
    logic [31:0]      cycle_count_d;
    logic [XLEN-1:0]  reg_sig_d;

    always_comb begin
        back_edge     = (pc == LOOP_PC) && (pc_next == LOOP_TARGET);
        loop_count_d  = loop_count_q;
        cycle_count_d = cycle_count_q;
        reg_sig_d     = reg_sig_q;
        if (back_edge && (loop_count_q != {CNT_W{1'b1}})) begin
            loop_count_d = loop_count_q + 1'b1;
        end
        if (cycle_count_q != 32'hFFFF_FFFF) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        // x0 is hard-wired zero in the core, so its writes carry no information.
        if (reg_we && (reg_waddr != 5'd0)) begin
            reg_sig_d = {reg_sig_q[XLEN-2:0], reg_sig_q[XLEN-1]}
                        ^ reg_wdata ^ XLEN'(reg_waddr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            loop_count_q  <= '0;
            cycle_count_q <= '0;
            reg_sig_q     <= '0;
        end else if (clear) begin
            // Clear wins everywhere except that IDLE still honours start.
            state_q       <= (state_q == S_IDLE && start) ? S_RUN : S_IDLE;
            loop_count_q  <= '0;
            cycle_count_q <= '0;
            reg_sig_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    loop_count_q  <= loop_count_d;
                    cycle_count_q <= cycle_count_d;
                    reg_sig_q     <= reg_sig_d;
                    // The loop limit is checked before the timeout, so a tie ends in DONE.
                    if (32'(loop_count_d) > LIMIT_U) begin
                        state_q <= S_DONE;
                    end else if (cycle_count_d == TIMEOUT_U) begin
                        state_q <= S_TIMEOUT;
                    end
                end
                default: begin
                    // DONE / TIMEOUT: sticky, everything frozen until clear.
                    state_q <= state_q;
                end
            endcase
        end
    end

`ifdef RUN_MON_MEM_SIG_EN
    logic [XLEN-1:0] mem_sig_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mem_sig_q <= '0;
        end else if ((state_q == S_RUN) && mem_we) begin
            mem_sig_q <= {mem_sig_q[XLEN-2:0], mem_sig_q[XLEN-1]}
                         ^ mem_wdata ^ mem_addr;
        end
    end

    assign mem_sig = mem_sig_q;
`else
    logic unused_mem_port;
    assign unused_mem_port = ^{mem_we, mem_addr, mem_wdata};
    assign mem_sig = '0;
`endif

    assign status      = state_q;
    assign halt        = state_q[1];
    assign loop_count  = loop_count_q;
    assign cycle_count = cycle_count_q;
    assign reg_sig     = reg_sig_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: three instances with different loop/timeout limits.
// All three share one stimulus. Vector table, directed corner sequences, then random stimulus against a model.
// No flow control is involved. Inputs are driven 1ns after the rising edge, and outputs are sampled at the same point.
module tb_cpu_run_monitor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clear, reg_we, mem_we;
    logic [31:0] pc, pc_next, reg_wdata, mem_addr, mem_wdata;
    logic [4:0]  reg_waddr;

    logic        halt_o [3];
    logic [1:0]  st_o   [3];
    logic [7:0]  lc_o   [3];
    logic [31:0] cc_o   [3];
    logic [31:0] rs_o   [3];
    logic [31:0] ms_o   [3];

    cpu_run_monitor u_a (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .pc(pc), .pc_next(pc_next),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .halt(halt_o[0]), .status(st_o[0]), .loop_count(lc_o[0]),
        .cycle_count(cc_o[0]), .reg_sig(rs_o[0]), .mem_sig(ms_o[0]));

    cpu_run_monitor #(.LOOP_LIMIT(10), .TIMEOUT_CYCLES(20)) u_b (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .pc(pc), .pc_next(pc_next),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .halt(halt_o[1]), .status(st_o[1]), .loop_count(lc_o[1]),
        .cycle_count(cc_o[1]), .reg_sig(rs_o[1]), .mem_sig(ms_o[1]));

    cpu_run_monitor #(.LOOP_LIMIT(0), .TIMEOUT_CYCLES(1)) u_c (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .pc(pc), .pc_next(pc_next),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .halt(halt_o[2]), .status(st_o[2]), .loop_count(lc_o[2]),
        .cycle_count(cc_o[2]), .reg_sig(rs_o[2]), .mem_sig(ms_o[2]));

    int nvec  = 0;
    int nfail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 1'b0; start = 1'b0; clear = 1'b0;
        pc = 32'h2000; pc_next = 32'h2004;
        reg_we = 1'b0; reg_waddr = 5'd0; reg_wdata = 32'h0;
        mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model (one per instance) ----------------
    int          m_lim [3] = '{10, 10, 0};
    int          m_to  [3] = '{1000, 20, 1};
    int          m_st  [3];
    longint      m_lc  [3];
    longint      m_cc  [3];
    logic [31:0] m_rs  [3];
    logic [31:0] m_ms  [3];

    function automatic logic [31:0] rotl1(input logic [31:0] v);
        return {v[30:0], v[31]};
    endfunction

    task automatic model_zero(input int k);
        m_lc[k] = 0; m_cc[k] = 0; m_rs[k] = 32'h0; m_ms[k] = 32'h0;
    endtask

    task automatic model_step(input int k);
        if (rst) begin
            model_zero(k);
            m_st[k] = 0;
        end else if (m_st[k] == 0) begin
            if (start) m_st[k] = 1;
        end else if (m_st[k] == 1) begin
            if (clear) begin
                model_zero(k);
                m_st[k] = 0;
            end else begin
                if (m_cc[k] < 64'hFFFF_FFFF) m_cc[k] = m_cc[k] + 1;
                if (pc == 32'h100C && pc_next == 32'h1000 && m_lc[k] < 255) m_lc[k] = m_lc[k] + 1;
                if (reg_we && reg_waddr != 5'd0)
                    m_rs[k] = rotl1(m_rs[k]) ^ reg_wdata ^ {27'd0, reg_waddr};
`ifdef RUN_MON_MEM_SIG_EN
                if (mem_we) m_ms[k] = rotl1(m_ms[k]) ^ mem_wdata ^ mem_addr;
`endif
                if (m_lc[k] > m_lim[k])       m_st[k] = 2;
                else if (m_cc[k] == m_to[k])  m_st[k] = 3;
            end
        end else begin
            if (clear) begin
                model_zero(k);
                m_st[k] = 0;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        start, clear;
        logic [31:0] pc, pc_next;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  st;
        logic [7:0]  lc;
        logic [31:0] cc, rs;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic c, input logic [31:0] p, input logic [31:0] pn,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [1:0] st, input logic [7:0] lc, input logic [31:0] cc,
                                input logic [31:0] rs);
        vec_t v;
        v.start = s; v.clear = c; v.pc = p; v.pc_next = pn; v.we = we; v.wa = wa; v.wd = wd;
        v.st = st; v.lc = lc; v.cc = cc; v.rs = rs;
        return v;
    endfunction

    vec_t tbl [12];
    logic [31:0] exp_ms;
    int          hat;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        //             st cl pc        pc_next   we wa     wd             st   lc  cc   rs
        tbl[0]  = mk(0, 0, 32'h100C, 32'h1000, 1, 5'd6, 32'h0000000A, 2'd0, 0, 0, 32'h0);
        tbl[1]  = mk(1, 0, 32'h100C, 32'h1000, 1, 5'd6, 32'h0000000A, 2'd1, 0, 0, 32'h0);
        tbl[2]  = mk(0, 0, 32'h2000, 32'h2004, 1, 5'd6, 32'h0000000A, 2'd1, 0, 1, 32'h0C);
        tbl[3]  = mk(0, 0, 32'h2000, 32'h2004, 1, 5'd0, 32'hFFFFFFFF, 2'd1, 0, 2, 32'h0C);
        tbl[4]  = mk(0, 0, 32'h2000, 32'h2004, 1, 5'd4, 32'h0000000E, 2'd1, 0, 3, 32'h12);
        tbl[5]  = mk(0, 0, 32'h100C, 32'h1000, 0, 5'd0, 32'h0,        2'd1, 1, 4, 32'h12);
        tbl[6]  = mk(0, 0, 32'h100C, 32'h1010, 0, 5'd0, 32'h0,        2'd1, 1, 5, 32'h12);
        tbl[7]  = mk(0, 0, 32'h1000, 32'h1000, 0, 5'd0, 32'h0,        2'd1, 1, 6, 32'h12);
        tbl[8]  = mk(1, 0, 32'h2000, 32'h2004, 0, 5'd0, 32'h0,        2'd1, 1, 7, 32'h12);
        tbl[9]  = mk(0, 1, 32'h100C, 32'h1000, 1, 5'd3, 32'h5,        2'd0, 0, 0, 32'h0);
        tbl[10] = mk(1, 1, 32'h2000, 32'h2004, 0, 5'd0, 32'h0,        2'd1, 0, 0, 32'h0);
        tbl[11] = mk(0, 0, 32'h100C, 32'h1000, 1, 5'd1, 32'h100,      2'd1, 1, 1, 32'h101);

`ifdef RUN_MON_MEM_SIG_EN
        exp_ms = 32'h00002002;
`else
        exp_ms = 32'h0;
`endif

        // ---- reset state ----
        do_reset();
        check("rst_status", 64'(st_o[0]), 0);
        check("rst_halt", 64'(halt_o[0]), 0);
        check("rst_loop", 64'(lc_o[0]), 0);
        check("rst_cycle", 64'(cc_o[0]), 0);
        check("rst_regsig", 64'(rs_o[0]), 0);
        check("rst_memsig", 64'(ms_o[0]), 0);

        // ---- table ----
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start; clear = tbl[i].clear;
            pc = tbl[i].pc; pc_next = tbl[i].pc_next;
            reg_we = tbl[i].we; reg_waddr = tbl[i].wa; reg_wdata = tbl[i].wd;
            tick();
            check($sformatf("tbl%0d_status", i), 64'(st_o[0]), 64'(tbl[i].st));
            check($sformatf("tbl%0d_loop", i), 64'(lc_o[0]), 64'(tbl[i].lc));
            check($sformatf("tbl%0d_cycle", i), 64'(cc_o[0]), 64'(tbl[i].cc));
            check($sformatf("tbl%0d_regsig", i), 64'(rs_o[0]), 64'(tbl[i].rs));
        end

        // ---- nominal loop: DONE after the 11th back-edge ----
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        hat = -1;
        for (int i = 0; i < 200; i++) begin
            pc      = 32'h1000 + 32'(4 * (i % 4));
            pc_next = (i % 4 == 3) ? 32'h1000 : pc + 32'd4;
            tick();
            if (halt_o[0]) begin
                hat = i + 1;
                break;
            end
        end
        check("nom_halt_cycle", 64'(hat), 44);
        check("nom_status", 64'(st_o[0]), 2);
        check("nom_loop", 64'(lc_o[0]), 11);
        check("nom_cycle", 64'(cc_o[0]), 44);
        // sticky: further back-edges, writes and start do nothing
        start = 1'b1; pc = 32'h100C; pc_next = 32'h1000; reg_we = 1'b1; reg_waddr = 5'd7; reg_wdata = 32'h55;
        tick(); tick(); tick();
        quiet();
        check("nom_sticky_status", 64'(st_o[0]), 2);
        check("nom_sticky_loop", 64'(lc_o[0]), 11);
        check("nom_sticky_cycle", 64'(cc_o[0]), 44);
        check("nom_sticky_regsig", 64'(rs_o[0]), 0);

        // ---- timeout (TIMEOUT_CYCLES=20) ----
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        pc = 32'h1000; pc_next = 32'h1004;
        for (int i = 0; i < 19; i++) tick();
        check("to_pre_status", 64'(st_o[1]), 1);
        check("to_pre_cycle", 64'(cc_o[1]), 19);
        tick();
        check("to_status", 64'(st_o[1]), 3);
        check("to_halt", 64'(halt_o[1]), 1);
        check("to_cycle", 64'(cc_o[1]), 20);
        check("to_loop", 64'(lc_o[1]), 0);
        tick();
        check("to_frozen_cycle", 64'(cc_o[1]), 20);

        // ---- tie: LOOP_LIMIT=0, TIMEOUT_CYCLES=1 ----
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        pc = 32'h100C; pc_next = 32'h1000;
        tick();
        check("tie_status", 64'(st_o[2]), 2);
        check("tie_loop", 64'(lc_o[2]), 1);
        check("tie_cycle", 64'(cc_o[2]), 1);

        // ---- reset mid-run with loop_count=5 ----
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        reg_we = 1'b1; reg_waddr = 5'd9; reg_wdata = 32'hA5A5;
        for (int i = 0; i < 20; i++) begin
            pc      = 32'h1000 + 32'(4 * (i % 4));
            pc_next = (i % 4 == 3) ? 32'h1000 : pc + 32'd4;
            tick();
        end
        check("mid_loop", 64'(lc_o[0]), 5);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        quiet();
        tick();
        check("mid_rst_status", 64'(st_o[0]), 0);
        check("mid_rst_halt", 64'(halt_o[0]), 0);
        check("mid_rst_loop", 64'(lc_o[0]), 0);
        check("mid_rst_cycle", 64'(cc_o[0]), 0);
        check("mid_rst_regsig", 64'(rs_o[0]), 0);

        // ---- memory signature and clear ----
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        mem_we = 1'b1; mem_addr = 32'h2008; mem_wdata = 32'h0000000A;
        reg_we = 1'b1; reg_waddr = 5'd2; reg_wdata = 32'h10;
        tick();
        quiet();
        check("mem_sig", 64'(ms_o[0]), 64'(exp_ms));
        check("mem_regsig", 64'(rs_o[0]), 32'h12);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_status", 64'(st_o[0]), 0);
        check("clr_regsig", 64'(rs_o[0]), 0);
        check("clr_memsig", 64'(ms_o[0]), 0);

        // ---- random stimulus against the model ----
        do_reset();
        for (int k = 0; k < 3; k++) begin
            model_zero(k);
            m_st[k] = 0;
        end
        for (int n = 0; n < 2000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 5) == 0);
            clear     = ($urandom_range(0, 29) == 0);
            pc        = 32'h1000 + 32'(4 * $urandom_range(0, 3));
            pc_next   = ($urandom_range(0, 1) == 1) ? 32'h1000 : pc + 32'd4;
            reg_we    = 1'($urandom_range(0, 1));
            reg_waddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            reg_wdata = $urandom;
            mem_we    = 1'($urandom_range(0, 1));
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            for (int k = 0; k < 3; k++) model_step(k);
            tick();
            for (int k = 0; k < 3; k++) begin
                check($sformatf("rnd%0d_u%0d_status", n, k), 64'(st_o[k]), 64'(m_st[k]));
                check($sformatf("rnd%0d_u%0d_halt", n, k), 64'(halt_o[k]), 64'(m_st[k] >= 2));
                check($sformatf("rnd%0d_u%0d_loop", n, k), 64'(lc_o[k]), 64'(m_lc[k]));
                check($sformatf("rnd%0d_u%0d_cycle", n, k), 64'(cc_o[k]), 64'(m_cc[k]));
                check($sformatf("rnd%0d_u%0d_regsig", n, k), 64'(rs_o[k]), 64'(m_rs[k]));
                check($sformatf("rnd%0d_u%0d_memsig", n, k), 64'(ms_o[k]), 64'(m_ms[k]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
